// File: rtl/spi_slave_burst.sv
// SPI register slave supporting all four modes, burst access with address wrap,
// and a per-write strobe/address sideband. Fully synchronous to clk.
`timescale 1ns/1ps
module spi_slave_burst #(
    parameter int unsigned RW_REG_COUNT = 12,
    parameter int unsigned RO_REG_COUNT = 1,
    parameter int unsigned CPOL         = 0,
    parameter int unsigned CPHA         = 0,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter logic [7:0]  RST_VALUE    = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      spi_cs,
    input  logic                      spi_clk,
    input  logic                      spi_mosi,
    output logic                      spi_miso,
    output logic                      spi_miso_oe,
    output logic [RW_REG_COUNT*8-1:0] rw_data,
    input  logic [RO_REG_COUNT*8-1:0] ro_data,
    output logic                      wr_strobe,
    output logic [6:0]                wr_addr
);

    localparam int unsigned TOTAL     = RW_REG_COUNT + RO_REG_COUNT;
    localparam logic [7:0]  RW_END    = 8'(RW_REG_COUNT);
    localparam logic [6:0]  LAST_ADDR = 7'(TOTAL - 1);

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] cs_q, sclk_q, mosi_q;
    logic       sclk_prev;
    logic       cs_s, sclk_s, mosi_s;
    logic       rise, fall, leading, trailing, sample_edge, shift_edge;

    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic [6:0] addr;
    logic [7:0] tx_buf;
    logic [7:0] rw_regs [RW_REG_COUNT];

    logic [7:0] cmd_byte;
    logic [6:0] next_addr;
    logic [6:0] fetch_addr;
    logic [7:0] fetch_data;
    logic       byte_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q      <= '1;
            sclk_q    <= (CPOL != 0) ? '1 : '0;
            mosi_q    <= '0;
            sclk_prev <= (CPOL != 0);
        end else begin
            cs_q      <= {cs_q[SYNC_STAGES-2:0], spi_cs};
            sclk_q    <= {sclk_q[SYNC_STAGES-2:0], spi_clk};
            mosi_q    <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev <= sclk_s;
        end
    end

    assign cs_s   = cs_q[SYNC_STAGES-1];
    assign sclk_s = sclk_q[SYNC_STAGES-1];
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    assign rise        = sclk_s & ~sclk_prev;
    assign fall        = ~sclk_s & sclk_prev;
    assign leading     = (CPOL != 0) ? fall : rise;
    assign trailing    = (CPOL != 0) ? rise : fall;
    assign sample_edge = (CPHA != 0) ? trailing : leading;
    assign shift_edge  = (CPHA != 0) ? leading : trailing;

    assign spi_miso_oe = ~cs_s;
    assign cmd_byte    = {shreg, mosi_s};
    assign byte_done   = sample_edge && (bit_cnt == 3'd7) && (state != IDLE);
    assign next_addr   = (addr == LAST_ADDR) ? 7'd0 : addr + 7'd1;
    assign fetch_addr  = (state == CMD) ? cmd_byte[6:0] : next_addr;

    always_comb begin
        fetch_data = 8'hFF;
        for (int unsigned i = 0; i < RW_REG_COUNT; i++) begin
            if (fetch_addr == 7'(i)) fetch_data = rw_regs[i];
        end
        for (int unsigned i = 0; i < RO_REG_COUNT; i++) begin
            if ({1'b0, fetch_addr} == 8'(RW_REG_COUNT + i)) fetch_data = ro_data[i*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (cs_s) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = CMD;
                CMD:     if (byte_done) state_next = cmd_byte[7] ? WDATA : RDATA;
                default: state_next = state;
            endcase
        end
    end

    // Any sample edge coinciding with a cs release is dropped by the cs_s priority here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            addr      <= '0;
            tx_buf    <= '0;
            spi_miso  <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            for (int unsigned i = 0; i < RW_REG_COUNT; i++) rw_regs[i] <= RST_VALUE;
        end else begin
            wr_strobe <= 1'b0;
            if (cs_s) begin
                bit_cnt  <= '0;
                spi_miso <= 1'b0;
            end else begin
                if (sample_edge && state != IDLE) begin
                    shreg   <= {shreg[5:0], mosi_s};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    case (state)
                        CMD: begin
                            addr   <= cmd_byte[6:0];
                            tx_buf <= fetch_data;
                        end
                        WDATA: begin
                            if ({1'b0, addr} < RW_END) begin
                                for (int unsigned i = 0; i < RW_REG_COUNT; i++) begin
                                    if (addr == 7'(i)) rw_regs[i] <= cmd_byte;
                                end
                                wr_strobe <= 1'b1;
                                wr_addr   <= addr;
                            end
                            addr <= next_addr;
                        end
                        RDATA: begin
                            addr   <= next_addr;
                            tx_buf <= fetch_data;
                        end
                        default: ;
                    endcase
                end
                if (shift_edge) begin
                    if (state == RDATA) begin
                        spi_miso <= tx_buf[7];
                        tx_buf   <= {tx_buf[6:0], 1'b0};
                    end else begin
                        spi_miso <= 1'b0;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < RW_REG_COUNT; g++) begin : g_flat
        assign rw_data[g*8 +: 8] = rw_regs[g];
    end

endmodule

// File: doc/spi_slave_burst.md
Name: spi_slave_burst

Overview:
Next-generation SPI register slave with all four SPI modes (CPOL/CPHA), multi-byte burst transfers with address auto-increment and wrap, and configurable input synchronisation. It exposes the same flat register map as the existing slave: read-write registers in the low addresses and read-only registers above them. It adds a write-strobe/address sideband, so downstream logic can react to individual register writes. Sits between the chip pads and the design's control registers, clocked entirely by the system clock.

Parameters:
RW_REG_COUNT, 12, number of 8-bit read-write registers (addresses 0..RW_REG_COUNT-1)
RO_REG_COUNT, 1, number of 8-bit read-only registers (addresses RW_REG_COUNT..TOTAL-1, TOTAL=RW+RO, TOTAL<=128)
CPOL, 0, idle level of spi_clk
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
SYNC_STAGES, 2, flip-flop stages on spi_clk/spi_cs/spi_mosi (>=2)
RST_VALUE, 0, reset byte for every rw register

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
spi_cs  in  1  chip select, active low
spi_clk  in  1  SPI clock
spi_mosi  in  1  master-out data
spi_miso  out  1  slave-out data
spi_miso_oe  out  1  MISO output enable (high while selected)
rw_data  out  RW_REG_COUNT*8  flattened read-write registers, reg i at [8i+7:8i]
ro_data  in  RO_REG_COUNT*8  flattened read-only registers
wr_strobe  out  1  one-clk pulse per committed write
wr_addr  out  7  address of the committed write (valid with wr_strobe)

Behaviour:
- Reset (async, rst_n low): all rw registers = RST_VALUE; spi_miso=0, spi_miso_oe=0, wr_strobe=0, wr_addr=0; state IDLE; bit counter 0; synchronisers cleared to inactive (cs=1, clk=CPOL).
- All SPI inputs pass through SYNC_STAGES flops; edges are detected on the synchronised spi_clk. Requirement: clk >= 8x spi_clk.
- Leading edge = rising if CPOL=0, falling if CPOL=1. Sample edge = leading if CPHA=0, else trailing. Shift edge = the other one.
- Frame: byte 0 = command {rw, addr[6:0]}, rw=1 write, rw=0 read. Bytes 1..N = data. MSB first throughout.
- States: IDLE -> CMD on synced cs low. CMD -> WDATA or RDATA after the 8th sample edge. Any state -> IDLE on synced cs high (same cycle).
- CMD: spi_miso drives 0. On the 8th sample edge, latch addr.
  - Read: fetch byte(addr) into the tx buffer at that edge.
  - Fetch returns rw reg if addr<RW_REG_COUNT, ro_data if addr<TOTAL, else 8'hFF.
- WDATA: on each 8th sample edge, commit the byte.
  - If addr<RW_REG_COUNT: rw register updated on the next clk; wr_strobe high for exactly that clk; wr_addr=addr.
  - Writes to RO or invalid addresses are dropped with no strobe.
  - Then addr increments.
- RDATA:
  - CPHA=0: the tx buffer MSB is driven on spi_miso at the shift edge that ends the previous byte; remaining bits go out on subsequent shift edges.
  - CPHA=1: each bit (MSB first) is driven on the shift (leading) edge of its bit slot.
  - At each 8th sample edge, addr increments and the next byte is fetched (snapshot at that edge, so ro_data changes mid-byte are not seen).
- Address increment: addr+1; if addr==TOTAL-1, wraps to 0. Out-of-range start addresses increment to 127 then wrap to 0.
- cs deasserted mid-byte: partial byte discarded, no write, no strobe; bit counter cleared. Committed bytes of that burst remain.
- spi_miso_oe = synced cs low. spi_miso returns to 0 in IDLE.
- A sample edge and cs rise in the same synchronised cycle: cs rise wins, and the edge is ignored.

Test Plan:
- Mode 0 single write: cmd 0x83, data 0x5A -> rw reg 3 = 0x5A; one wr_strobe, wr_addr=3; other regs unchanged.
- Mode 0 burst write wrap (RW=12, RO=1): cmd 0x8B, data 0x11,0x22,0x33 -> reg11=0x11; addr 12 (RO) dropped with no strobe; wrap gives reg0=0x33; exactly two strobes.
- Mode 3 burst read: preload reg1=0xA5, reg2=0x3C, ro_data=0xC7; cmd 0x01 then 3 dummy bytes -> MISO returns 0xA5, 0x3C, 0xFF for addr 3 (regs zero after reset unless set; set reg3=0xFF), with correct bit timing for CPOL=1/CPHA=1.
- Read RO/invalid in mode 1: cmd 0x0C -> 0xC7; cmd 0x40 -> 0xFF.
- cs abort: cmd 0x85, 5 bits of data, cs high -> reg5 unchanged, no strobe. A new frame writing reg5=0x77 then succeeds.
- Reset mid-frame: assert rst_n low during a data byte -> all regs = RST_VALUE, outputs 0 immediately. The next full frame after release works normally.
